uart_tx: RTL and testbench
==========================

# uart_tx

Parametrised UART transmitter: the next-generation serial send block, replacing the fixed 8-bit, fixed-rate sender. It serialises one word per start/ready handshake into a complete asynchronous frame (start bit, LSB-first data, optional parity, one or two stop bits) at a configurable bit period, and reports frame completion. It sits between on-chip logic and the board UART TX pin, clocked from the 100 MHz system clock.

## Interface
- CLK_DIV, 868: clock cycles per bit (868 = 115200 baud at 100 MHz); legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  request to send `data`; accepted only when `ready` is high.
- data  in  DATA_BITS  word to send; sampled on the accepting edge only.
- ready  out  1  high when a new `start` will be accepted.
- busy  out  1  high while a frame is on the line.
- signal  out  1  serial line; idle high.
- done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE → START → DATA → PARITY (only when PARITY ≠ 0) → STOP → IDLE.
- IDLE: `signal` = 1, `ready` = 1, `busy` = 0. On `start & ready`: latch `data` into the shift register, compute the parity bit from the latched word, clear the bit counter, go to START.
- START: `signal` = 0 for CLK_DIV cycles.
- DATA: shift out LSB first, DATA_BITS bits, each lasting CLK_DIV cycles.
- PARITY: odd means data plus parity has an odd count of ones; even means an even count.
- STOP: `signal` = 1 for STOP_BITS × CLK_DIV cycles. On the final cycle: pulse `done`, raise `ready`, return to IDLE.
- `start` while `ready` = 0 is ignored. It is not queued. `data` changes during a frame have no effect.
- Bit timing: a down-counter of width $clog2(CLK_DIV) reloads to CLK_DIV−1 on acceptance and at every bit boundary. No drift between frames.
- Reset, including mid-frame: immediately `signal` = 1, `ready` = 1, `busy` = 0, `done` = 0, state = IDLE, counters = 0. No partial frame resumes.

## Timing
- All outputs are registered.
- Acceptance edge N: `signal` falls at edge N+1, `busy` rises at N+1, `ready` falls at N+1.
- Frame length is exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles, measured from the falling edge of `signal`.
- `done` and `ready` rise together in the last cycle of the stop period.
- Back-to-back: `start` asserted in the `done` cycle is accepted. The next start bit follows with zero idle cycles.

## Configuration
- UART_TX_BREAK_EN: adds input `brk` (1 bit).
  - While `brk` = 1 and the state is IDLE, `signal` = 0 and `ready` = 0.
  - `brk` asserted mid-frame takes effect only after that frame's `done`.
  - Releasing `brk` returns `signal` high on the next edge; `ready` follows one cycle later.
- Without the macro: no `brk` port, and the line is driven only by the frame FSM.

## Structure
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - parity localparams PAR_NONE, PAR_ODD, PAR_EVEN.
  - default CLK_DIV constant.
- Sub-module uart_baud_gen (CLK_DIV): generates the bit-period tick, with a synchronous `restart` input used on acceptance. It is the parametrised successor of the old pulse generator.

## Test plan
- Reset: hold `rst` = 0 → `signal` = 1, `ready` = 1, `busy` = 0, `done` = 0. Assert reset mid-frame → `signal` = 1 within the same cycle.
- CLK_DIV = 4, 8N1, data = 8'h64 → line reads 0,0,0,1,0,0,1,1,0,1, each bit 4 cycles wide. Frame = 40 cycles; `done` pulses once.
- PARITY = 2 with data = 8'h07 → parity bit 1. PARITY = 1 with data = 8'h07 → parity bit 0. DATA_BITS = 7, STOP_BITS = 2 → frame = 11 × CLK_DIV cycles.
- `start` held high continuously with data 8'hA5 then 8'h5A → two frames with no idle gap; second frame's start bit begins the cycle after `done`.
- `start` pulsed mid-frame with different `data` → ignored; the current frame is unchanged and no extra frame is sent.
- UART_TX_BREAK_EN: `brk` raised during DATA → frame completes, then `signal` = 0 and `ready` = 0. Release `brk` → `signal` = 1 next edge, `ready` = 1 one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared state encoding, parity modes and defaults for the UART TX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int CLK_DIV_DEFAULT = 868;

  // Word is zero-extended by the caller, so padding never changes the result.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module : uart_baud_gen
// Brief  : Bit-period down-counter; tick marks the last cycle of each bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == '0)) begin
      r_cnt <= CW'(CLK_DIV - 1);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick      = (r_cnt == '0);
  assign tick_next = (r_cnt == CW'(1));

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : Parametrised UART transmitter (start, LSB-first data, optional
//          parity, 1/2 stop bits). UART_TX_BREAK_EN adds the brk input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 signal,
  output logic                 done
);

  localparam logic [3:0] C_DATA_BITS = 4'(DATA_BITS);
  localparam logic [3:0] C_LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [3:0]           r_bit_cnt;
  logic                 r_signal;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic w_brk;
  logic w_accept;
  logic w_tick;
  logic w_tick_next;

`ifdef UART_TX_BREAK_EN
  assign w_brk = brk;
`else
  assign w_brk = 1'b0;
`endif

  assign w_accept = start & r_ready;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart   (w_accept),
    .tick      (w_tick),
    .tick_next (w_tick_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
      r_signal  <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Acceptance also covers the done cycle, giving gap-free back-to-back frames.
      if (w_accept) begin
        r_state   <= S_START;
        r_shift   <= data;
        r_par     <= parity_bit(9'(data), PARITY);
        r_bit_cnt <= '0;
        r_signal  <= 1'b0;
        r_ready   <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Ready trails the line by a cycle when a break is released.
            r_signal <= ~w_brk;
            r_ready  <= ~w_brk & r_signal;
          end
          S_START: begin
            if (w_tick) begin
              r_state   <= S_DATA;
              r_signal  <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= 4'd1;
            end
          end
          S_DATA: begin
            if (w_tick) begin
              if (r_bit_cnt == C_DATA_BITS) begin
                r_bit_cnt <= '0;
                if (PARITY != PAR_NONE) begin
                  r_state  <= S_PARITY;
                  r_signal <= r_par;
                end else begin
                  r_state  <= S_STOP;
                  r_signal <= 1'b1;
                end
              end else begin
                r_signal  <= r_shift[0];
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_PARITY: begin
            if (w_tick) begin
              r_state  <= S_STOP;
              r_signal <= 1'b1;
            end
          end
          S_STOP: begin
            if (r_bit_cnt == C_LAST_STOP) begin
              if (w_tick_next) begin
                r_done  <= 1'b1;
                r_ready <= 1'b1;
              end
              if (w_tick) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_signal <= ~w_brk;
                r_ready  <= ~w_brk;
              end
            end else if (w_tick) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign signal = r_signal;
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module : tb_uart_tx
// Brief  : Scoreboard bench for uart_tx over three configurations
//          (UART_TX_BREAK_EN adds a break scenario on instance 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [8:0] d [3];
  logic [2:0] mon_off;
  wire  [2:0] sig, rdy, bsy, dn;
`ifdef UART_TX_BREAK_EN
  logic [2:0] brk;
`endif

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk[0]),
`endif
    .start(st[0]), .data(d[0][7:0]),
    .ready(rdy[0]), .busy(bsy[0]), .signal(sig[0]), .done(dn[0]));

  uart_tx #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk[1]),
`endif
    .start(st[1]), .data(d[1][6:0]),
    .ready(rdy[1]), .busy(bsy[1]), .signal(sig[1]), .done(dn[1]));

  uart_tx #(.CLK_DIV(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk[2]),
`endif
    .start(st[2]), .data(d[2]),
    .ready(rdy[2]), .busy(bsy[2]), .signal(sig[2]), .done(dn[2]));

  function automatic int cdiv(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int dbits(input int k);
    case (k)
      0:       return 8;
      1:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int pmode(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sbits(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  // Expected line levels, one entry per bit period, from the frame format alone.
  function automatic void model(input int k, input logic [8:0] w,
                                output logic [15:0] bits, output int n);
    int ones;
    bits = '1;
    bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dbits(k); i++) begin
      bits[1 + i] = w[i];
      ones += int'(w[i]);
    end
    n = 1 + dbits(k);
    if (pmode(k) == 1) begin
      bits[n] = (ones % 2 == 0);
      n++;
    end else if (pmode(k) == 2) begin
      bits[n] = (ones % 2 == 1);
      n++;
    end
    n += sbits(k);
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic monitor(input int k);
    exp_t        e;
    int          cd;
    logic [15:0] got;
    bit          bad_b, bad_h, bad_y, aborted;
    cd = cdiv(k);
    forever begin
      @(negedge clk);
      if (!rst || mon_off[k]) continue;
      if (sig[k]) begin
        chk(rdy[k] && !bsy[k] && !dn[k], $sformatf("idle_outputs inst%0d", k),
            {29'd0, rdy[k], bsy[k], dn[k]}, 3'b100);
        continue;
      end
      if (q[k].size() == 0) begin
        chk(1'b0, $sformatf("unexpected_frame inst%0d", k), 1, 0);
        continue;
      end
      e = q[k].pop_front();
      chk(cyc == e.cyc, $sformatf("start_latency inst%0d", k), cyc, e.cyc);
      got = '1; bad_b = 0; bad_h = 0; bad_y = 0; aborted = 0;
      for (int i = 0; i < e.n * cd; i++) begin
        if (i > 0) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1;
            break;
          end
        end
        got[i / cd] = sig[k];
        if (sig[k] !== e.bits[i / cd]) bad_b = 1;
        if (dn[k] !== (i == e.n * cd - 1) || rdy[k] !== (i == e.n * cd - 1)) bad_h = 1;
        if (bsy[k] !== 1'b1) bad_y = 1;
      end
      if (!aborted) begin
        chk(!bad_b, $sformatf("frame_bits inst%0d", k), int'(got), int'(e.bits));
        chk(!bad_h, $sformatf("done_ready_timing inst%0d", k), int'(bad_h), 0);
        chk(!bad_y, $sformatf("busy_in_frame inst%0d", k), int'(bad_y), 0);
      end
    end
  endtask

  // Called negedge-aligned; returns negedge-aligned after frame (+gap).
  task automatic send(input int k, input logic [8:0] w, input int gap,
                      input bit glitch, input bit hold);
    exp_t e;
    int   l, j;
    d[k]  = w;
    st[k] = 1'b1;
    @(posedge clk); #1;
    model(k, w, e.bits, e.n);
    e.cyc = cyc;
    q[k].push_back(e);
    if (!hold) st[k] = 1'b0;
    d[k] = 9'($urandom);
    l = e.n * cdiv(k);
    if (glitch) begin
      j = $urandom_range(l - 1, 1);
      repeat (j - 1) @(posedge clk);
      @(negedge clk);
      st[k] = 1'b1;
      d[k]  = 9'($urandom);
      @(posedge clk); #1;
      if (!hold) st[k] = 1'b0;
      repeat (l - 1 - j) @(posedge clk);
    end else begin
      repeat (l - 1) @(posedge clk);
    end
    repeat (gap) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [8:0] rand_word(input int k);
    logic [8:0] m;
    m = 9'((1 << dbits(k)) - 1);
    return 9'($urandom) & m;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      automatic int kk = k;
      fork
        monitor(kk);
      join_none
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    st = '0;
    mon_off = '0;
    for (int k = 0; k < 3; k++) d[k] = '0;
`ifdef UART_TX_BREAK_EN
    brk = '0;
`endif
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(sig[k] == 1'b1, $sformatf("reset_signal inst%0d", k), int'(sig[k]), 1);
      chk(rdy[k] == 1'b1, $sformatf("reset_ready inst%0d", k), int'(rdy[k]), 1);
      chk(bsy[k] == 1'b0, $sformatf("reset_busy inst%0d", k), int'(bsy[k]), 0);
      chk(dn[k] == 1'b0, $sformatf("reset_done inst%0d", k), int'(dn[k]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    send(0, 9'h064, 2, 1'b0, 1'b0);
    send(1, 9'h007, 2, 1'b0, 1'b0);
    send(2, 9'h007, 1, 1'b0, 1'b0);
    send(0, 9'h0A5, 0, 1'b0, 1'b1);
    send(0, 9'h05A, 3, 1'b0, 1'b0);
    send(0, 9'h0C3, 1, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        send(k, rand_word(k), $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'b0);
      end
    end

    // Reset in the middle of a frame must force the idle line at once.
    d[0] = 9'h1F0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    begin
      exp_t e;
      model(0, 9'h1F0, e.bits, e.n);
      e.cyc = cyc;
      q[0].push_back(e);
    end
    st[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk(sig[0] == 1'b1, "midframe_reset_signal", int'(sig[0]), 1);
    chk(rdy[0] == 1'b1, "midframe_reset_ready", int'(rdy[0]), 1);
    chk(bsy[0] == 1'b0, "midframe_reset_busy", int'(bsy[0]), 0);
    chk(dn[0] == 1'b0, "midframe_reset_done", int'(dn[0]), 0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    send(0, rand_word(0), 1, 1'b0, 1'b0);

`ifdef UART_TX_BREAK_EN
    d[0] = 9'h03C;
    st[0] = 1'b1;
    @(posedge clk); #1;
    begin
      exp_t e;
      model(0, 9'h03C, e.bits, e.n);
      e.cyc = cyc;
      q[0].push_back(e);
    end
    st[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    brk[0] = 1'b1;
    mon_off[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk(sig[0] == 1'b0, "brk_after_done_signal", int'(sig[0]), 0);
    chk(rdy[0] == 1'b0, "brk_after_done_ready", int'(rdy[0]), 0);
    chk(bsy[0] == 1'b0, "brk_after_done_busy", int'(bsy[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    chk(sig[0] == 1'b0, "brk_hold_signal", int'(sig[0]), 0);
    chk(rdy[0] == 1'b0, "brk_hold_ready", int'(rdy[0]), 0);
    brk[0] = 1'b0;
    @(posedge clk); #1;
    chk(sig[0] == 1'b1, "brk_release_signal", int'(sig[0]), 1);
    chk(rdy[0] == 1'b0, "brk_release_ready_lag", int'(rdy[0]), 0);
    @(posedge clk); #1;
    chk(rdy[0] == 1'b1, "brk_release_ready", int'(rdy[0]), 1);
    mon_off[0] = 1'b0;
    @(negedge clk);
    send(0, rand_word(0), 1, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(q[k].size() == 0, $sformatf("frames_outstanding inst%0d", k), q[k].size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
